mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one word-wide main-memory port between the instruction cache (read-only line refills) and the data cache (line refills and line write-backs).
- Sequences each grant as a fixed-length word burst covering one cache line.
- Generates per-word addresses and forwards data in both directions.
- Signals line completion back to the owning cache, so cache miss stalls can be released.

Parameters:
LINE_WORDS, 8, words per cache line (power of two, ≥2)
CNT_W, 3, log2(LINE_WORDS), width of burst word counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_req  in  1  ICache line read request, held until i_done
i_addr  in  32  ICache line address (low log2(LINE_WORDS)+2 bits ignored)
i_rdata  out  32  read word to ICache
i_rvalid  out  1  i_rdata valid this cycle
i_done  out  1  one-cycle pulse, ICache burst complete
d_req  in  1  DCache line request, held until d_done
d_wr  in  1  1 = write-back burst, 0 = refill; sampled at grant
d_addr  in  32  DCache line address (low bits ignored as for i_addr)
d_wdata  in  32  current write-back word
d_wdata_rd  out  1  pulse: word consumed, DCache presents next word next cycle
d_rdata  out  32  read word to DCache
d_rvalid  out  1  d_rdata valid this cycle
d_done  out  1  one-cycle pulse, DCache burst complete
mem_req  out  1  memory access request
mem_wr  out  1  memory write strobe qualifier
mem_addr  out  32  word address (byte address, bits[1:0]=0)
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  memory completes current word this cycle
owner  out  2  00 none, 01 ICache, 10 DCache (debug/perf)

Behaviour:
- States: IDLE, BURST, DONE.
- Reset (async, any state, including mid-burst): state = IDLE, counter = 0, last-winner = ICache. All outputs are 0, including owner and the registered rdata. An aborted burst is not resumed; requesters re-request after reset.
- IDLE:
  - No request: stay IDLE.
  - Only one request: grant that requester.
  - Both requests in the same cycle: grant the requester that did not win last (round-robin).
  - On grant:
    - Latch line base = addr with low log2(LINE_WORDS)+2 bits cleared.
    - Latch owner.
    - Latch wr = (owner==D) & d_wr.
    - Set counter = 0.
    - Go to BURST next cycle.
  - Grant latency: request seen in cycle N → mem_req=1 in cycle N+1.
- BURST:
  - Drive mem_req=1, mem_wr=latched wr, mem_addr = base + 4·counter.
  - mem_wdata = d_wdata (combinational passthrough); it is 0 when not a write burst.
  - On mem_ack:
    - Counter increments.
    - Write burst: d_wdata_rd=1 in the same cycle.
    - Read burst: mem_rdata is registered into owner's rdata; rvalid pulses the following cycle.
  - mem_req stays high across words. The address changes the cycle after ack.
  - Counter is CNT_W bits and wraps to 0 on the last ack.
  - Last ack (counter == LINE_WORDS-1): go to DONE.
- DONE (one cycle):
  - Owner's done = 1.
  - For a read burst, this cycle also carries rvalid for the last word.
  - mem_req = 0.
  - Record last-winner = owner, then go to IDLE.
  - Arbitration resumes in IDLE next cycle. Minimum gap between bursts: 2 cycles with mem_req=0 (DONE plus IDLE).
- Ownership rules:
  - Requests are ignored while BURST/DONE; d_wr and the addr inputs are not re-sampled mid-burst.
  - A requester deasserting req mid-burst does not abort: the burst completes and done still pulses.
  - Non-owner rvalid, done and d_wdata_rd stay 0 for the whole burst.
- mem_ack while state != BURST is ignored.
- owner output = 00 in IDLE, latched owner in BURST/DONE.
- i_rdata/d_rdata hold their last value when rvalid=0.

Test Plan:
1. Reset, LINE_WORDS=8; i_req=1, i_addr=0x0000_103C, mem_ack every cycle → cycle+1 mem_req=1. mem_addr steps 0x1020, 0x1024…0x103C. Eight i_rvalid pulses carry mem_rdata values; i_done=1 with the 8th rvalid. d_* outputs stay 0.
2. d_req=1, d_wr=1, d_addr=0x2000, mem_ack asserted every other cycle → mem_wr=1. mem_wdata tracks d_wdata; d_wdata_rd pulses exactly 8 times, aligned to acks. Each address is held until its ack; d_done pulses once; no d_rvalid.
3. i_req and d_req both rise in the same cycle after reset (last-winner=I) → DCache granted first. ICache, still requesting, is granted in the first IDLE after d_done. If both are requesting at that point, ICache wins.
4. Burst in progress for ICache; d_req asserted at word 3 → ignored until DONE; d_req is granted in the next IDLE. ICache data and address sequence are undisturbed.
5. rst pulsed asynchronously mid-burst at word 5 → all outputs 0 immediately, owner=00. A fresh i_req afterwards restarts at word 0 of the new line.
6. i_req dropped after word 2 → burst continues to 8 words and i_done pulses. A stray mem_ack in IDLE produces no rvalid or done.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port between ICache refills
// and DCache refills/write-backs, each grant being one fixed-length line burst.
module mem_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wdata_rd,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int OFF_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [1:0] OWN_I = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_d;
  logic             grant_i;
  logic             grant_d;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  // mem_wr is only ever set for a DCache write-back burst, so it qualifies both paths
  assign mem_wdata  = mem_wr ? d_wdata : 32'd0;
  assign d_wdata_rd = mem_wr & mem_ack;

  // Arbitration: a lone requester wins, a tie goes to whoever did not win last
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
      grant_i = last_d;
      grant_d = ~last_d;
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
  end

  // Burst sequencer with all memory-side and cache-side status registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      last_d   <= 1'b0;
      owner    <= 2'b00;
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= 32'd0;
      i_rdata  <= 32'd0;
      i_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_rdata  <= 32'd0;
      d_rvalid <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state    <= BURST;
            cnt      <= {CNT_W{1'b0}};
            mem_req  <= 1'b1;
            owner    <= grant_d ? OWN_D : OWN_I;
            mem_wr   <= grant_d & d_wr;
            mem_addr <= grant_d ? {d_addr[31:OFF_W], {OFF_W{1'b0}}}
                                : {i_addr[31:OFF_W], {OFF_W{1'b0}}};
          end else begin
            state <= IDLE;
          end
        end
        BURST: begin
          if (mem_ack) begin
            cnt <= cnt + CNT_W'(1);
            if (!mem_wr) begin
              if (owner == OWN_I) begin
                i_rdata  <= mem_rdata;
                i_rvalid <= 1'b1;
              end else begin
                d_rdata  <= mem_rdata;
                d_rvalid <= 1'b1;
              end
            end
            if (cnt == CNT_LAST) begin
              state    <= DONE;
              mem_req  <= 1'b0;
              mem_wr   <= 1'b0;
              mem_addr <= 32'd0;
              i_done   <= (owner == OWN_I);
              d_done   <= (owner == OWN_D);
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        DONE: begin
          last_d <= (owner == OWN_D);
          owner  <= 2'b00;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          owner   <= 2'b00;
          mem_req <= 1'b0;
          mem_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model is checked against the
// DUT every cycle, plus literal spot checks of grant order, latency and counts.
module tb_mem_arbiter;
  localparam int LINE_WORDS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_rvalid, i_done, d_wdata_rd, d_rvalid, d_done, mem_req, mem_wr;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_mode = 2;
  int cyc = 0;
  int wcnt = 0;
  int c_irv = 0, c_drv = 0, c_ido = 0, c_ddo = 0, c_wrd = 0;
  int s_irv, s_drv, s_ido, s_ddo, s_wrd;

  mem_arbiter #(.LINE_WORDS(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wdata_rd(d_wdata_rd),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Model: one burst = LINE_WORDS words at base + 4*word, then a single done cycle
  int          m_word;
  logic        m_busy, m_fin, m_wr, m_last_d;
  logic [1:0]  m_owner;
  logic [31:0] m_base, m_ird, m_drd;
  logic        m_irv, m_drv, m_idone, m_ddone;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_word <= 0; m_busy <= 1'b0; m_fin <= 1'b0; m_wr <= 1'b0; m_last_d <= 1'b0;
      m_owner <= 2'd0; m_base <= 32'd0; m_ird <= 32'd0; m_drd <= 32'd0;
      m_irv <= 1'b0; m_drv <= 1'b0; m_idone <= 1'b0; m_ddone <= 1'b0;
    end else begin
      m_irv <= 1'b0; m_drv <= 1'b0; m_idone <= 1'b0; m_ddone <= 1'b0;
      if (m_fin) begin
        m_last_d <= (m_owner == 2'd2);
        m_owner  <= 2'd0;
        m_fin    <= 1'b0;
      end else if (m_busy) begin
        if (mem_ack) begin
          if (!m_wr && m_owner == 2'd1) begin m_ird <= mem_rdata; m_irv <= 1'b1; end
          if (!m_wr && m_owner == 2'd2) begin m_drd <= mem_rdata; m_drv <= 1'b1; end
          if (m_word == LINE_WORDS - 1) begin
            m_busy <= 1'b0; m_fin <= 1'b1; m_word <= 0;
            m_idone <= (m_owner == 2'd1); m_ddone <= (m_owner == 2'd2);
          end else begin
            m_word <= m_word + 1;
          end
        end
      end else if (i_req || d_req) begin
        m_busy <= 1'b1;
        m_word <= 0;
        if (d_req && (!i_req || !m_last_d)) begin
          m_owner <= 2'd2; m_wr <= d_wr;
          m_base  <= d_addr & ~(32'(LINE_WORDS * 4) - 32'd1);
        end else begin
          m_owner <= 2'd1; m_wr <= 1'b0;
          m_base  <= i_addr & ~(32'(LINE_WORDS * 4) - 32'd1);
        end
      end
    end
  end

  // Compare process: every output against the model, once per cycle
  always @(negedge clk) begin
    chk("mem_req",    mem_req,    m_busy);
    chk("mem_wr",     mem_wr,     m_busy & m_wr);
    chk("mem_addr",   mem_addr,   m_busy ? m_base + 32'(m_word * 4) : 32'd0);
    chk("mem_wdata",  mem_wdata,  (m_busy && m_wr) ? d_wdata : 32'd0);
    chk("d_wdata_rd", d_wdata_rd, m_busy & m_wr & mem_ack);
    chk("i_rvalid",   i_rvalid,   m_irv);
    chk("d_rvalid",   d_rvalid,   m_drv);
    chk("i_rdata",    i_rdata,    m_ird);
    chk("d_rdata",    d_rdata,    m_drd);
    chk("i_done",     i_done,     m_idone);
    chk("d_done",     d_done,     m_ddone);
    chk("owner",      owner,      m_owner);
    if (i_rvalid)   c_irv++;
    if (d_rvalid)   c_drv++;
    if (i_done)     c_ido++;
    if (d_done)     c_ddo++;
    if (d_wdata_rd) c_wrd++;
  end

  task automatic step();
    logic adv;
    adv = d_wdata_rd;
    @(posedge clk);
    #1;
    if (adv) begin
      wcnt++;
      d_wdata = 32'hDA7A_0000 + 32'(wcnt);
    end
    cyc++;
    mem_rdata = 32'hC0DE_0000 + 32'(cyc);
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = ~mem_ack;
      default: mem_ack = 1'b0;
    endcase
  endtask

  task automatic wait_done(input bit dsel, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      seen = dsel ? d_done : i_done;
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_addr(input logic [31:0] target, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      step();
      seen = (mem_req && mem_addr == target);
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  task automatic snap();
    s_irv = c_irv; s_drv = c_drv; s_ido = c_ido; s_ddo = c_ddo; s_wrd = c_wrd;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_ack = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'hDA7A_0000; mem_rdata = 32'd0;
    step(); step();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_owner",   owner,   2'b00);
    chk("rst_i_rdata", i_rdata, 32'd0);
    rst = 1'b0;
    step();

    // 1: ICache refill, ack every cycle
    ack_mode = 0; i_addr = 32'h0000_103C; i_req = 1'b1;
    chk("t1_no_req_yet", mem_req, 1'b0);
    snap();
    step();
    chk("t1_latency", mem_req, 1'b1);
    chk("t1_first_addr", mem_addr, 32'h0000_1020);
    wait_addr(32'h0000_103C, "t1_last_addr");
    wait_done(1'b0, "t1_done_timeout");
    i_req = 1'b0;
    step();
    chk("t1_rvalid_cnt", 32'(c_irv - s_irv), 32'd8);
    chk("t1_done_cnt",   32'(c_ido - s_ido), 32'd1);
    chk("t1_d_quiet",    32'(c_drv - s_drv + c_ddo - s_ddo + c_wrd - s_wrd), 32'd0);

    // 2: DCache write-back, ack every other cycle
    ack_mode = 1; d_addr = 32'h0000_2000; d_wr = 1'b1; d_req = 1'b1;
    snap();
    step();
    chk("t2_mem_wr", mem_wr, 1'b1);
    wait_done(1'b1, "t2_done_timeout");
    d_req = 1'b0; d_wr = 1'b0;
    step();
    chk("t2_wdata_rd_cnt", 32'(c_wrd - s_wrd), 32'd8);
    chk("t2_d_done_cnt",   32'(c_ddo - s_ddo), 32'd1);
    chk("t2_no_rvalid",    32'(c_drv - s_drv + c_irv - s_irv), 32'd0);

    // 3: simultaneous requests after reset go to DCache, then ICache
    ack_mode = 0;
    rst = 1'b1; step(); rst = 1'b0;
    i_addr = 32'h0000_4000; d_addr = 32'h0000_3040; d_wr = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    step();
    chk("t3_first_owner", owner, 2'b10);
    chk("t3_first_addr",  mem_addr, 32'h0000_3040);
    wait_done(1'b1, "t3_d_done_timeout");
    step(); step();
    chk("t3_second_owner", owner, 2'b01);
    chk("t3_second_addr",  mem_addr, 32'h0000_4000);
    wait_done(1'b0, "t3_i_done_timeout");
    i_req = 1'b0; d_req = 1'b0;
    step();

    // 4: DCache request during an ICache burst waits for the next IDLE
    i_addr = 32'h0000_4800; i_req = 1'b1;
    wait_addr(32'h0000_480C, "t4_word3");
    d_addr = 32'h0000_5000; d_wr = 1'b0; d_req = 1'b1;
    wait_done(1'b0, "t4_i_done_timeout");
    i_req = 1'b0;
    step(); step();
    chk("t4_d_owner", owner, 2'b10);
    chk("t4_d_addr",  mem_addr, 32'h0000_5000);
    wait_done(1'b1, "t4_d_done_timeout");
    d_req = 1'b0;
    step();

    // 5: asynchronous reset mid-burst, then a fresh line
    i_addr = 32'h0000_6100; i_req = 1'b1;
    wait_addr(32'h0000_6114, "t5_word5");
    #2 rst = 1'b1;
    #1;
    chk("t5_async_mem_req",  mem_req,  1'b0);
    chk("t5_async_owner",    owner,    2'b00);
    chk("t5_async_mem_addr", mem_addr, 32'd0);
    chk("t5_async_i_rdata",  i_rdata,  32'd0);
    i_addr = 32'h0000_620C;
    step();
    rst = 1'b0;
    step();
    chk("t5_restart_addr",  mem_addr, 32'h0000_6200);
    chk("t5_restart_owner", owner,    2'b01);
    wait_done(1'b0, "t5_done_timeout");
    i_req = 1'b0;
    step();

    // 6: request dropped mid-burst still completes; stray acks in IDLE ignored
    i_addr = 32'h0000_7000; i_req = 1'b1;
    snap();
    wait_addr(32'h0000_700C, "t6_word3");
    i_req = 1'b0;
    wait_done(1'b0, "t6_done_timeout");
    step();
    chk("t6_rvalid_cnt", 32'(c_irv - s_irv), 32'd8);
    snap();
    for (int k = 0; k < 4; k++) step();
    chk("t6_idle_quiet", 32'(c_irv - s_irv + c_ido - s_ido), 32'd0);
    chk("t6_idle_req",   mem_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
